// File: rtl/uart_bus_master.sv
// Bus initiator for the word-wide UART peripheral: TX words become write requests, RX words are
// pulled with read requests. Optional watchdog enabled by defining UART_BUS_MASTER_WDOG_EN.
module uart_bus_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tx_word_valid,
  output logic        tx_word_ready,
  input  logic [31:0] tx_word,
  output logic        rx_word_valid,
  input  logic        rx_word_ready,
  output logic [31:0] rx_word,
  input  logic        uart_rx_empty,
  output logic        read,
  output logic        write,
  input  logic        read_response,
  input  logic        write_response,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic        timeout_flag
);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrWait,
    StRdReq,
    StRdWait,
    StDrain
  } state_e;

  localparam logic GrantRead  = 1'b0;
  localparam logic GrantWrite = 1'b1;

  state_e      state_q, state_d;
  logic        wr_pending_q, wr_pending_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] rx_word_q, rx_word_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rd_eligible;

  assign tx_word_ready = !wr_pending_q;
  assign rx_word_valid = rx_valid_q;
  assign rx_word       = rx_word_q;
  assign write_data    = write_data_q;
  assign address       = BASE_ADDR;
  assign rd_eligible   = !uart_rx_empty && !rx_valid_q;

  always_comb begin
    state_d      = state_q;
    wr_pending_d = wr_pending_q;
    last_grant_d = last_grant_q;
    write_data_d = write_data_q;
    rx_word_d    = rx_word_q;
    rx_valid_d   = rx_valid_q;
    read         = 1'b0;
    write        = 1'b0;

    if (tx_word_valid && tx_word_ready) begin
      write_data_d = tx_word;
      wr_pending_d = 1'b1;
    end
    if (rx_valid_q && rx_word_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // Round-robin only matters when both sides want the bus.
        if (wr_pending_q && rd_eligible) begin
          if (last_grant_q == GrantRead) begin
            state_d      = StWrReq;
            last_grant_d = GrantWrite;
          end else begin
            state_d      = StRdReq;
            last_grant_d = GrantRead;
          end
        end else if (wr_pending_q) begin
          state_d      = StWrReq;
          last_grant_d = GrantWrite;
        end else if (rd_eligible) begin
          state_d      = StRdReq;
          last_grant_d = GrantRead;
        end
      end
      StWrReq: begin
        write   = 1'b1;
        state_d = StWrWait;
      end
      StRdReq: begin
        read    = 1'b1;
        state_d = StRdWait;
      end
      StWrWait: begin
        if (write_response) begin
          wr_pending_d = 1'b0;
          state_d      = StDrain;
        end
      end
      StRdWait: begin
        if (read_response) begin
          rx_word_d  = read_data;
          rx_valid_d = 1'b1;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        // Responses last two cycles; wait out the second so it is not seen again.
        if (!read_response && !write_response) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      wr_pending_q <= 1'b0;
      last_grant_q <= GrantRead;
      write_data_q <= '0;
      rx_word_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_pending_q <= wr_pending_d;
      last_grant_q <= last_grant_d;
      write_data_q <= write_data_d;
      rx_word_q    <= rx_word_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

`ifdef UART_BUS_MASTER_WDOG_EN
  logic [31:0] wdog_cnt_q;
  logic        timeout_q;
  logic        wait_entry;
  logic        in_wait;

  assign in_wait      = (state_q == StWrWait) || (state_q == StRdWait);
  assign wait_entry   = !in_wait && ((state_d == StWrWait) || (state_d == StRdWait));
  assign timeout_flag = timeout_q;

  // Flags only; the transaction keeps waiting. TIMEOUT_CYCLES must be at least 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (wait_entry) begin
      wdog_cnt_q <= '0;
    end else if (in_wait) begin
      if (wdog_cnt_q != '1) begin
        wdog_cnt_q <= wdog_cnt_q + 32'd1;
      end
      if (wdog_cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  // Watchdog absent; the parameter stays for a uniform interface and folds to zero here.
  assign timeout_flag = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

endmodule
